ifetch: RTL and testbench
=========================

Name: ifetch

Overview:
- Instruction-fetch stage at the head of the pipeline.
- Owns the PC and drives the single-outstanding instruction-memory read handshake.
- Registers fetched instructions into the fetch/decode output register.
- Obeys the global stall and bubble signals from the hazard unit; accepts PC redirects from the resolving branch stage.
- Its imem_read_v_o / imem_resp_v_i pair is the same pair the hazard unit monitors.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
NOP_INSTR, 32'h0000_0013, value placed on instr_o at reset (addi x0,x0,0)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
imem_read_v_o  out  1  instruction read request valid
imem_addr_o  out  32  instruction read address (word aligned)
imem_resp_v_i  in  1  read response valid, one cycle
imem_data_i  in  32  read data, valid with imem_resp_v_i
stall_v_i  in  1  global stall from hazard unit
bubble_v_i  in  1  branch in flight from hazard unit; do not deliver new instructions
redir_v_i  in  1  PC redirect (taken branch/jump), one cycle
redir_pc_i  in  32  redirect target; bits [1:0] ignored (forced to 0)
instr_v_o  out  1  output register valid
instr_o  out  32  output register instruction
pc_o  out  32  PC of instr_o

Behaviour:
- Interface: one clock (clk_i); reset_i is synchronous, active-high. All state updates on the rising edge of clk_i.
- States:
  - WAIT: no request outstanding.
  - FETCH: request outstanding.
  - HOLD: response buffered, decode stalled.
  - KILL: request outstanding, result to be discarded.
- Reset values: state=WAIT, pc_r=RESET_PC, instr_v_o=0, instr_o=NOP_INSTR, pc_o=0, hold buffer cleared.
- Request outputs: imem_read_v_o = 1 in FETCH and KILL only; imem_addr_o = pc_r.
  - Once raised, imem_read_v_o and imem_addr_o stay stable until the cycle imem_resp_v_i=1.
  - Only one request outstanding at a time.
- WAIT: if ~bubble_v_i and ~redir_v_i, go FETCH. The request is visible the next cycle.
- FETCH with imem_resp_v_i=1:
  - bubble_v_i=1: discard data, pc_r unchanged, go WAIT.
  - ~stall_v_i: output reg <= {1, imem_data_i, pc_r}; pc_r <= pc_r+4; stay FETCH. Back-to-back throughput is 1 instr per response.
  - stall_v_i: buffer {data, pc_r}, pc_r <= pc_r+4, go HOLD.
- HOLD: imem_read_v_o=0. When ~stall_v_i, output reg <= {1, buffer}, go FETCH (or WAIT if bubble_v_i).
- KILL: when imem_resp_v_i, discard data, go WAIT.
- Output register:
  - Holds its value while stall_v_i=1.
  - When ~stall_v_i and no instruction is delivered this cycle, instr_v_o <= 0; instr_o and pc_o hold.
- Redirect: redir_v_i has priority over all other events, including stall and response in the same cycle.
  - pc_r <= {redir_pc_i[31:2],2'b00}.
  - instr_v_o <= 0.
  - Hold buffer dropped.
  - Next state: FETCH (no resp this cycle) → KILL; FETCH with resp this cycle → WAIT; HOLD → WAIT; KILL stays KILL; WAIT stays WAIT.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- reset_i mid-request: state returns to WAIT, and the next response with no request outstanding is ignored. The memory must tolerate the dropped request.
- imem_resp_v_i in WAIT or HOLD is ignored.

Optional Feature:
- Macro: RVGA_IFETCH_PERF_EN.
- Defined:
  - Adds ports fetch_count_o (out, 32) and stall_count_o (out, 32); both reset to 0 and wrap modulo 2^32.
  - fetch_count_o increments on each cycle an instruction is loaded with instr_v_o=1.
  - stall_count_o increments on each cycle stall_v_i=1.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, no stall, memory responding 1 cycle after request with data=addr: instr_v_o pulses with pc_o=0,4,8 and instr_o equal to pc_o; imem_addr_o never changes while imem_read_v_o=1 and no resp.
- Response at pc 0x10 coincides with stall_v_i=1 for 3 cycles: state goes HOLD, imem_read_v_o=0; on stall release instr_o=data, pc_o=0x10, next request addr 0x14.
- redir_v_i with redir_pc_i=0x0000_0103 while request to 0x20 is outstanding: request held until resp, that data never reaches instr_o, next imem_addr_o=0x100.
- bubble_v_i=1 for 4 cycles from WAIT: imem_read_v_o stays 0, instr_v_o=0; after drop, request to the unchanged pc_r.
- Simultaneous redir_v_i, imem_resp_v_i and stall_v_i in FETCH: response discarded, instr_v_o=0, pc_r=target, state WAIT; reset asserted mid-FETCH: pc_r=RESET_PC, state WAIT next cycle.
- With RVGA_IFETCH_PERF_EN: 5 delivered instrs and 3 stall cycles → fetch_count_o=5, stall_count_o=3.

Source files
------------

// File: rtl/ifetch_if.sv
// Instruction-memory read handshake between the fetch stage (master) and imem (slave).
// Signal suffixes are from the fetch stage's point of view.
interface ifetch_if;
  localparam int unsigned XLEN = 32;

  logic            imem_read_v_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_resp_v_i;
  logic [XLEN-1:0] imem_data_i;

  modport master (
    output imem_read_v_o,
    output imem_addr_o,
    input  imem_resp_v_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_read_v_o,
    input  imem_addr_o,
    output imem_resp_v_i,
    output imem_data_i
  );
endinterface

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem reads, fills the F/D register.
// Optional performance counters are enabled with `define RVGA_IFETCH_PERF_EN.
module ifetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_i,
  ifetch_if.master    imem,
  input  logic        stall_v_i,
  input  logic        bubble_v_i,
  input  logic        redir_v_i,
  input  logic [31:0] redir_pc_i,
  output logic        instr_v_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
`ifdef RVGA_IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_count_o,
  output logic [31:0] stall_count_o
`endif
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {WAIT, FETCH, HOLD, KILL} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] buf_instr_q;
  logic [XLEN-1:0] buf_pc_q;
  logic            instr_v_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_pc_q;

  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] redir_target_c;
  logic            resp_c;
  logic            deliver_c;

  assign pc_plus4_c     = pc_q + XLEN'(4);
  assign redir_target_c = redir_pc_i & ~XLEN'(3);
  assign resp_c         = imem.imem_resp_v_i;
  assign deliver_c      = !redir_v_i && !stall_v_i &&
                          ((state_q == FETCH && resp_c && !bubble_v_i) || state_q == HOLD);

  // addr_q only moves when a new request is launched, so it stays put across KILL.
  assign imem.imem_read_v_o = (state_q == FETCH) || (state_q == KILL);
  assign imem.imem_addr_o   = addr_q;
  assign instr_v_o          = instr_v_q;
  assign instr_o            = instr_q;
  assign pc_o               = instr_pc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= WAIT;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      instr_v_q   <= 1'b0;
      instr_q     <= NOP_INSTR;
      instr_pc_q  <= '0;
    end else if (redir_v_i) begin
      // A redirect overrides stall and any same-cycle response.
      pc_q        <= redir_target_c;
      instr_v_q   <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      state_q     <= ((state_q == FETCH || state_q == KILL) && !resp_c) ? KILL : WAIT;
    end else begin
      if (!stall_v_i) instr_v_q <= 1'b0;
      case (state_q)
        WAIT: begin
          if (!bubble_v_i) begin
            state_q <= FETCH;
            addr_q  <= pc_q;
          end
        end
        FETCH: begin
          if (resp_c) begin
            if (bubble_v_i) begin
              state_q <= WAIT;
            end else if (!stall_v_i) begin
              instr_v_q  <= 1'b1;
              instr_q    <= imem.imem_data_i;
              instr_pc_q <= pc_q;
              pc_q       <= pc_plus4_c;
              addr_q     <= pc_plus4_c;
            end else begin
              buf_instr_q <= imem.imem_data_i;
              buf_pc_q    <= pc_q;
              pc_q        <= pc_plus4_c;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_v_i) begin
            instr_v_q  <= 1'b1;
            instr_q    <= buf_instr_q;
            instr_pc_q <= buf_pc_q;
            addr_q     <= pc_q;
            state_q    <= bubble_v_i ? WAIT : FETCH;
          end
        end
        KILL: begin
          if (resp_c) state_q <= WAIT;
        end
        default: state_q <= WAIT;
      endcase
    end
  end

`ifdef RVGA_IFETCH_PERF_EN
  logic [XLEN-1:0] fetch_count_q;
  logic [XLEN-1:0] stall_count_q;

  assign fetch_count_o = fetch_count_q;
  assign stall_count_o = stall_count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (deliver_c) fetch_count_q <= fetch_count_q + XLEN'(1);
      if (stall_v_i) stall_count_q <= stall_count_q + XLEN'(1);
    end
  end
`endif
endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch; imem responses are driven by hand from each test.
module tb_ifetch;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        stall_v_i = 1'b0;
  logic        bubble_v_i = 1'b0;
  logic        redir_v_i = 1'b0;
  logic [31:0] redir_pc_i = 32'h0;
  logic        instr_v_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
`ifdef RVGA_IFETCH_PERF_EN
  logic [31:0] fetch_count_o;
  logic [31:0] stall_count_o;
`endif

  int total = 0;
  int bad   = 0;

  ifetch_if bus ();

  ifetch dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .imem       (bus),
    .stall_v_i  (stall_v_i),
    .bubble_v_i (bubble_v_i),
    .redir_v_i  (redir_v_i),
    .redir_pc_i (redir_pc_i),
    .instr_v_o  (instr_v_o),
    .instr_o    (instr_o),
    .pc_o       (pc_o)
`ifdef RVGA_IFETCH_PERF_EN
    ,
    .fetch_count_o (fetch_count_o),
    .stall_count_o (stall_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    bus.imem_resp_v_i = 1'b0;
    bus.imem_data_i   = 32'h0;
    reset_i = 1'b1;
    step;
    step;
    reset_i = 1'b0;
    total++; if (bus.imem_read_v_o !== 1'b0) begin bad++; $display("FAIL reset_rv got=%0b exp=0", bus.imem_read_v_o); end
    total++; if (bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=00000000", bus.imem_addr_o); end
    total++; if (instr_v_o !== 1'b0) begin bad++; $display("FAIL reset_iv got=%0b exp=0", instr_v_o); end
    total++; if (instr_o !== 32'h0000_0013) begin bad++; $display("FAIL reset_instr got=%h exp=00000013", instr_o); end
    total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=00000000", pc_o); end
  endtask

  task automatic test_fetch;
    logic [31:0] exp;
    step;
    total++; if (bus.imem_read_v_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL fetch_req got=%0b/%h exp=1/00000000", bus.imem_read_v_o, bus.imem_addr_o); end
    step;
    total++; if (bus.imem_read_v_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL fetch_stable got=%0b/%h exp=1/00000000", bus.imem_read_v_o, bus.imem_addr_o); end
    for (int i = 0; i < 3; i++) begin
      exp = 32'(i * 4);
      bus.imem_resp_v_i = 1'b1;
      bus.imem_data_i   = bus.imem_addr_o;
      step;
      bus.imem_resp_v_i = 1'b0;
      total++; if (instr_v_o !== 1'b1 || instr_o !== exp || pc_o !== exp) begin bad++; $display("FAIL fetch_out%0d got=%0b/%h/%h exp=1/%h/%h", i, instr_v_o, instr_o, pc_o, exp, exp); end
      total++; if (bus.imem_addr_o !== exp + 32'd4) begin bad++; $display("FAIL fetch_next%0d got=%h exp=%h", i, bus.imem_addr_o, exp + 32'd4); end
    end
    step;
    total++; if (instr_v_o !== 1'b0 || instr_o !== 32'h8) begin bad++; $display("FAIL fetch_idle got=%0b/%h exp=0/00000008", instr_v_o, instr_o); end
  endtask

  task automatic test_stall;
    bus.imem_resp_v_i = 1'b1;
    bus.imem_data_i   = 32'hC;
    step;
    stall_v_i = 1'b1;
    bus.imem_data_i = 32'hA000_0010;
    step;
    bus.imem_resp_v_i = 1'b0;
    total++; if (bus.imem_read_v_o !== 1'b0) begin bad++; $display("FAIL stall_hold_rv got=%0b exp=0", bus.imem_read_v_o); end
    total++; if (instr_v_o !== 1'b1 || instr_o !== 32'hC) begin bad++; $display("FAIL stall_held_out got=%0b/%h exp=1/0000000c", instr_v_o, instr_o); end
    bus.imem_resp_v_i = 1'b1;
    bus.imem_data_i   = 32'hBBBB_BBBB;
    step;
    bus.imem_resp_v_i = 1'b0;
    total++; if (bus.imem_read_v_o !== 1'b0) begin bad++; $display("FAIL stall_hold_rv2 got=%0b exp=0", bus.imem_read_v_o); end
    step;
    total++; if (bus.imem_read_v_o !== 1'b0 || instr_o !== 32'hC) begin bad++; $display("FAIL stall_hold3 got=%0b/%h exp=0/0000000c", bus.imem_read_v_o, instr_o); end
    stall_v_i = 1'b0;
    step;
    total++; if (instr_v_o !== 1'b1 || instr_o !== 32'hA000_0010 || pc_o !== 32'h10) begin bad++; $display("FAIL stall_release got=%0b/%h/%h exp=1/a0000010/00000010", instr_v_o, instr_o, pc_o); end
    total++; if (bus.imem_read_v_o !== 1'b1 || bus.imem_addr_o !== 32'h14) begin bad++; $display("FAIL stall_next_req got=%0b/%h exp=1/00000014", bus.imem_read_v_o, bus.imem_addr_o); end
  endtask

  task automatic test_redirect;
    for (int i = 0; i < 3; i++) begin
      bus.imem_resp_v_i = 1'b1;
      bus.imem_data_i   = 32'h14 + 32'(i * 4);
      step;
    end
    bus.imem_resp_v_i = 1'b0;
    total++; if (bus.imem_addr_o !== 32'h20) begin bad++; $display("FAIL redir_pre got=%h exp=00000020", bus.imem_addr_o); end
    redir_v_i  = 1'b1;
    redir_pc_i = 32'h0000_0103;
    step;
    redir_v_i = 1'b0;
    total++; if (bus.imem_read_v_o !== 1'b1 || bus.imem_addr_o !== 32'h20 || instr_v_o !== 1'b0) begin bad++; $display("FAIL redir_kill got=%0b/%h/%0b exp=1/00000020/0", bus.imem_read_v_o, bus.imem_addr_o, instr_v_o); end
    step;
    total++; if (bus.imem_read_v_o !== 1'b1 || bus.imem_addr_o !== 32'h20) begin bad++; $display("FAIL redir_kill_stable got=%0b/%h exp=1/00000020", bus.imem_read_v_o, bus.imem_addr_o); end
    bus.imem_resp_v_i = 1'b1;
    bus.imem_data_i   = 32'hBAD0_0020;
    step;
    bus.imem_resp_v_i = 1'b0;
    total++; if (bus.imem_read_v_o !== 1'b0 || instr_v_o !== 1'b0 || instr_o !== 32'h1C) begin bad++; $display("FAIL redir_discard got=%0b/%0b/%h exp=0/0/0000001c", bus.imem_read_v_o, instr_v_o, instr_o); end
    step;
    total++; if (bus.imem_read_v_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin bad++; $display("FAIL redir_target got=%0b/%h exp=1/00000100", bus.imem_read_v_o, bus.imem_addr_o); end
  endtask

  task automatic test_bubble;
    bubble_v_i = 1'b1;
    bus.imem_resp_v_i = 1'b1;
    bus.imem_data_i   = 32'h55;
    step;
    bus.imem_resp_v_i = 1'b0;
    total++; if (bus.imem_read_v_o !== 1'b0 || instr_v_o !== 1'b0) begin bad++; $display("FAIL bubble_drop got=%0b/%0b exp=0/0", bus.imem_read_v_o, instr_v_o); end
    for (int i = 0; i < 4; i++) begin
      step;
      total++; if (bus.imem_read_v_o !== 1'b0 || instr_v_o !== 1'b0) begin bad++; $display("FAIL bubble_wait%0d got=%0b/%0b exp=0/0", i, bus.imem_read_v_o, instr_v_o); end
    end
    bubble_v_i = 1'b0;
    step;
    total++; if (bus.imem_read_v_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin bad++; $display("FAIL bubble_resume got=%0b/%h exp=1/00000100", bus.imem_read_v_o, bus.imem_addr_o); end
  endtask

  task automatic test_collision;
    bus.imem_resp_v_i = 1'b1;
    bus.imem_data_i   = 32'h100;
    step;
    total++; if (instr_v_o !== 1'b1 || bus.imem_addr_o !== 32'h104) begin bad++; $display("FAIL coll_pre got=%0b/%h exp=1/00000104", instr_v_o, bus.imem_addr_o); end
    redir_v_i  = 1'b1;
    redir_pc_i = 32'h0000_0204;
    stall_v_i  = 1'b1;
    bus.imem_data_i = 32'h77;
    step;
    redir_v_i = 1'b0;
    stall_v_i = 1'b0;
    bus.imem_resp_v_i = 1'b0;
    total++; if (instr_v_o !== 1'b0 || bus.imem_read_v_o !== 1'b0 || instr_o !== 32'h100) begin bad++; $display("FAIL coll_out got=%0b/%0b/%h exp=0/0/00000100", instr_v_o, bus.imem_read_v_o, instr_o); end
    step;
    total++; if (bus.imem_read_v_o !== 1'b1 || bus.imem_addr_o !== 32'h204) begin bad++; $display("FAIL coll_target got=%0b/%h exp=1/00000204", bus.imem_read_v_o, bus.imem_addr_o); end
    reset_i = 1'b1;
    step;
    reset_i = 1'b0;
    total++; if (bus.imem_read_v_o !== 1'b0 || bus.imem_addr_o !== 32'h0 || instr_o !== 32'h13) begin bad++; $display("FAIL midreset got=%0b/%h/%h exp=0/00000000/00000013", bus.imem_read_v_o, bus.imem_addr_o, instr_o); end
    bus.imem_resp_v_i = 1'b1;
    bus.imem_data_i   = 32'hEEEE_EEEE;
    step;
    bus.imem_resp_v_i = 1'b0;
    total++; if (instr_v_o !== 1'b0 || bus.imem_read_v_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL stray_resp got=%0b/%0b/%h exp=0/1/00000000", instr_v_o, bus.imem_read_v_o, bus.imem_addr_o); end
  endtask

  task automatic test_wrap;
    redir_v_i  = 1'b1;
    redir_pc_i = 32'hFFFF_FFFE;
    step;
    redir_v_i = 1'b0;
    total++; if (bus.imem_read_v_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_kill got=%0b/%h exp=1/00000000", bus.imem_read_v_o, bus.imem_addr_o); end
    bus.imem_resp_v_i = 1'b1;
    bus.imem_data_i   = 32'hCAFE;
    step;
    bus.imem_resp_v_i = 1'b0;
    step;
    total++; if (bus.imem_read_v_o !== 1'b1 || bus.imem_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req got=%0b/%h exp=1/fffffffc", bus.imem_read_v_o, bus.imem_addr_o); end
    bus.imem_resp_v_i = 1'b1;
    bus.imem_data_i   = 32'h1234;
    step;
    bus.imem_resp_v_i = 1'b0;
    total++; if (instr_v_o !== 1'b1 || instr_o !== 32'h1234 || pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_out got=%0b/%h/%h exp=1/00001234/fffffffc", instr_v_o, instr_o, pc_o); end
    total++; if (bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_next got=%h exp=00000000", bus.imem_addr_o); end
  endtask

`ifdef RVGA_IFETCH_PERF_EN
  task automatic test_perf;
    reset_i = 1'b1;
    step;
    reset_i = 1'b0;
    step;
    for (int i = 0; i < 5; i++) begin
      bus.imem_resp_v_i = 1'b1;
      bus.imem_data_i   = 32'(i);
      step;
    end
    bus.imem_resp_v_i = 1'b0;
    stall_v_i = 1'b1;
    for (int i = 0; i < 3; i++) step;
    stall_v_i = 1'b0;
    total++; if (fetch_count_o !== 32'd5) begin bad++; $display("FAIL perf_fetch got=%0d exp=5", fetch_count_o); end
    total++; if (stall_count_o !== 32'd3) begin bad++; $display("FAIL perf_stall got=%0d exp=3", stall_count_o); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_fetch;
    test_stall;
    test_redirect;
    test_bubble;
    test_collision;
    test_wrap;
`ifdef RVGA_IFETCH_PERF_EN
    test_perf;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
